ex_mem_pipe: RTL and testbench

Parametrised EX→MEM pipeline stage for the multicycle/pipelined core. It adds valid/ready handshaking, a 2-entry skid buffer for full-throughput backpressure, flush (branch/exception squash) and a registered forwarding tap. Upstream is the ID/EX + ALU stage; downstream is the data-memory stage, which may stall through out_ready.

---
 rtl/ex_mem_pkg.sv | 32 +++
 rtl/pipe_skid_reg.sv | 91 +++++++++
 rtl/ex_mem_pipe.sv | 103 ++++++++++
 tb/tb_ex_mem_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline register: control bundle, payload and skid states.
package ex_mem_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;

  typedef struct packed {
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic branch;
    logic regwrite;
  } ex_mem_ctrl_t;

  // Default-width payload; ex_mem_pipe re-declares the same layout at its own widths.
  typedef struct packed {
    logic [XLEN_DEF-1:0]   pc;
    logic                  zero;
    logic [XLEN_DEF-1:0]   alu_result;
    logic [XLEN_DEF-1:0]   rs2;
    logic [REG_AW_DEF-1:0] rd;
    ex_mem_ctrl_t          ctrl;
  } ex_mem_payload_t;

  // Encoding is {skid_v, main_v}.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry valid/ready skid register with flush and synchronous active-low reset.
// in_ready is registered, so no combinational path runs from out_ready to in_ready.
module pipe_skid_reg
  import ex_mem_pkg::*;
#(
  parameter type T = logic [7:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  T           in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output T           out_data,
  output logic [1:0] occupancy
);

  skid_state_e state_q, state_d;
  T            main_q, main_d;
  T            skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  logic [1:0]  occ_q, occ_d;
  logic        accept_c;
  logic        release_c;

  assign accept_c  = in_valid & in_ready_q;
  assign release_c = state_q[0] & out_ready;

  // State and payload registers; reset overrides flush and every handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SKID_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
    end
  end

  // Next state; payload only moves on accept or skid->main, flush drops valids but keeps data.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept_c) begin
            main_d  = in_data;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept_c && release_c) begin
            main_d = in_data;
          end else if (accept_c) begin
            skid_d  = in_data;
            state_d = SKID_FULL;
          end else if (release_c) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (release_c) begin
            main_d  = skid_q;
            state_d = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
    in_ready_d = ~state_d[1];
    occ_d      = 2'(state_d[1]) + 2'(state_d[0]);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state_q[0];
  assign out_data  = main_q;
  assign occupancy = occ_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline stage: skid-buffered payload, optional control gating and a forwarding tap.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_AW    = 5,
  parameter bit          GATE_CTRL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_zero,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_memtoreg,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic              in_branch,
  input  logic              in_regwrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic              out_zero,
  output logic [XLEN-1:0]   out_alu_addr,
  output logic [XLEN-1:0]   out_wdata,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_memtoreg,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_branch,
  output logic              out_regwrite,
  output logic              fwd_en,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic [1:0]        occupancy
);

  // Same layout as ex_mem_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              zero;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   rs2;
    logic [REG_AW-1:0] rd;
    ex_mem_ctrl_t      ctrl;
  } payload_t;

  payload_t in_pl;
  payload_t out_pl;
  logic     ctrl_en;

  // Pack the incoming ID/EX fields.
  always_comb begin
    in_pl               = '0;
    in_pl.pc            = in_pc;
    in_pl.zero          = in_zero;
    in_pl.alu_result    = in_alu_result;
    in_pl.rs2           = in_rs2;
    in_pl.rd            = in_rd;
    in_pl.ctrl.memtoreg = in_memtoreg;
    in_pl.ctrl.memread  = in_memread;
    in_pl.ctrl.memwrite = in_memwrite;
    in_pl.ctrl.branch   = in_branch;
    in_pl.ctrl.regwrite = in_regwrite;
  end

  pipe_skid_reg #(.T(payload_t)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl),
    .occupancy (occupancy)
  );

  // Stale control bits of an invalid head must not reach memory when gating is on.
  assign ctrl_en = GATE_CTRL ? out_valid : 1'b1;

  assign out_pc       = out_pl.pc;
  assign out_zero     = out_pl.zero;
  assign out_alu_addr = out_pl.alu_result;
  assign out_wdata    = out_pl.rs2;
  assign out_rd       = out_pl.rd;
  assign out_memtoreg = out_pl.ctrl.memtoreg & ctrl_en;
  assign out_memread  = out_pl.ctrl.memread  & ctrl_en;
  assign out_memwrite = out_pl.ctrl.memwrite & ctrl_en;
  assign out_branch   = out_pl.ctrl.branch   & ctrl_en;
  assign out_regwrite = out_pl.ctrl.regwrite & ctrl_en;

  // Forwarding tap: x0 writes never forward.
  assign fwd_en   = out_valid & out_pl.ctrl.regwrite & (out_pl.rd != '0);
  assign fwd_rd   = out_pl.rd;
  assign fwd_data = out_pl.alu_result;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: a 32-bit and a 64-bit instance share the same stimulus.
`timescale 1ns/1ps
module tb_ex_mem_pipe;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] alu;
    logic [63:0] rs2;
    logic [4:0]  rd;
    logic        zero;
    logic [4:0]  ctrl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_alu, in_rs2;
  logic [63:0] in_pc64, in_alu64, in_rs2_64;
  logic        in_zero;
  logic [4:0]  in_rd;
  logic        in_memtoreg, in_memread, in_memwrite, in_branch, in_regwrite;

  logic        in_ready, out_valid, out_zero, fwd_en;
  logic [31:0] out_pc, out_alu, out_wdata, fwd_data;
  logic [4:0]  out_rd, fwd_rd;
  logic        out_memtoreg, out_memread, out_memwrite, out_branch, out_regwrite;
  logic [1:0]  occupancy;

  logic        in_ready64, out_valid64, out_zero64, fwd_en64;
  logic [63:0] out_pc64, out_alu64, out_wdata64, fwd_data64;
  logic [4:0]  out_rd64, fwd_rd64;
  logic        out_memtoreg64, out_memread64, out_memwrite64, out_branch64, out_regwrite64;
  logic [1:0]  occupancy64;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_zero(in_zero), .in_alu_result(in_alu), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_memtoreg(in_memtoreg), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_branch(in_branch), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_zero(out_zero),
    .out_alu_addr(out_alu), .out_wdata(out_wdata), .out_rd(out_rd),
    .out_memtoreg(out_memtoreg), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_branch(out_branch), .out_regwrite(out_regwrite),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .occupancy(occupancy)
  );

  ex_mem_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_pc(in_pc64), .in_zero(in_zero), .in_alu_result(in_alu64), .in_rs2(in_rs2_64), .in_rd(in_rd),
    .in_memtoreg(in_memtoreg), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_branch(in_branch), .in_regwrite(in_regwrite),
    .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64), .out_zero(out_zero64),
    .out_alu_addr(out_alu64), .out_wdata(out_wdata64), .out_rd(out_rd64),
    .out_memtoreg(out_memtoreg64), .out_memread(out_memread64), .out_memwrite(out_memwrite64),
    .out_branch(out_branch64), .out_regwrite(out_regwrite64),
    .fwd_en(fwd_en64), .fwd_rd(fwd_rd64), .fwd_data(fwd_data64), .occupancy(occupancy64)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // 32-bit monitor: every release must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q32.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL m32_unexpected: got pc 0x%0h, expected no output", out_pc);
      end else begin
        e32 = q32.pop_front();
        check("m32_pc",   {32'h0, out_pc},    {32'h0, e32.pc[31:0]});
        check("m32_alu",  {32'h0, out_alu},   {32'h0, e32.alu[31:0]});
        check("m32_wd",   {32'h0, out_wdata}, {32'h0, e32.rs2[31:0]});
        check("m32_rd",   64'(out_rd),        64'(e32.rd));
        check("m32_zero", 64'(out_zero),      64'(e32.zero));
        check("m32_ctrl", 64'({out_memtoreg, out_memread, out_memwrite, out_branch, out_regwrite}),
              64'(e32.ctrl));
        check("m32_fwd_en",   64'(fwd_en),       64'(e32.ctrl[0] && e32.rd != 5'd0));
        check("m32_fwd_rd",   64'(fwd_rd),       64'(e32.rd));
        check("m32_fwd_data", {32'h0, fwd_data}, {32'h0, e32.alu[31:0]});
      end
    end
  end

  // 64-bit monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid64 && out_ready) begin
      if (q64.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL m64_unexpected: got pc 0x%0h, expected no output", out_pc64);
      end else begin
        e64 = q64.pop_front();
        check("m64_pc",   out_pc64,    e64.pc);
        check("m64_alu",  out_alu64,   e64.alu);
        check("m64_wd",   out_wdata64, e64.rs2);
        check("m64_rd",   64'(out_rd64),   64'(e64.rd));
        check("m64_zero", 64'(out_zero64), 64'(e64.zero));
        check("m64_ctrl", 64'({out_memtoreg64, out_memread64, out_memwrite64, out_branch64,
                               out_regwrite64}), 64'(e64.ctrl));
        check("m64_fwd_en",   64'(fwd_en64), 64'(e64.ctrl[0] && e64.rd != 5'd0));
        check("m64_fwd_rd",   64'(fwd_rd64), 64'(e64.rd));
        check("m64_fwd_data", fwd_data64,    e64.alu);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one entry; push the expected result when the bench knows it will be accepted.
  task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                      input logic [4:0] rd, input logic [4:0] ctrl, input logic push);
    exp_t e;
    in_valid  = 1'b1;
    in_pc     = pc;
    in_alu    = alu;
    in_rs2    = rs2;
    in_pc64   = 64'h1_0000_0000 + 64'(pc);
    in_alu64  = {32'hA5A5_A5A5, alu};
    in_rs2_64 = {32'h5A5A_5A5A, rs2};
    in_rd     = rd;
    in_zero   = (alu == 32'h0);
    {in_memtoreg, in_memread, in_memwrite, in_branch, in_regwrite} = ctrl;
    if (push) begin
      e.pc = {32'h0, pc}; e.alu = {32'h0, alu}; e.rs2 = {32'h0, rs2};
      e.rd = rd; e.zero = (alu == 32'h0); e.ctrl = ctrl;
      q32.push_back(e);
      e.pc = 64'h1_0000_0000 + 64'(pc); e.alu = {32'hA5A5_A5A5, alu}; e.rs2 = {32'h5A5A_5A5A, rs2};
      q64.push_back(e);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_occ"},       64'(occupancy), 64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_occ64"},     64'(occupancy64), 64'd0);
    check({tag, "_in_ready64"}, 64'(in_ready64), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset with in_valid high
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    send(32'h0000_0BAD, 32'h1234, 32'h5678, 5'd3, 5'b11111, 1'b0);
    cycle(); cycle();
    check_idle("rst");
    check("rst_pc",   64'(out_pc),  64'd0);
    check("rst_alu",  64'(out_alu), 64'd0);
    check("rst_wd",   64'(out_wdata), 64'd0);
    check("rst_rd",   64'(out_rd),  64'd0);
    check("rst_ctrl", 64'({out_zero, out_memtoreg, out_memread, out_memwrite, out_branch,
                           out_regwrite, fwd_en}), 64'd0);
    check("rst_pc64", out_pc64, 64'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    cycle();

    // 2: streaming back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h100 + 32'(4 * i), 32'h40 + 32'(i), 32'h900 + 32'(i), 5'(i + 1), 5'b01001, 1'b1);
      cycle();
      check("s2_in_ready", 64'(in_ready), 64'd1);
      check("s2_occ",      64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    cycle();
    check_idle("s2_end");

    // 3: backpressure into the skid
    send(32'h200, 32'h2000, 32'h2222, 5'd7, 5'b10101, 1'b1);
    cycle();
    out_ready = 1'b0;
    send(32'h204, 32'h2004, 32'h2224, 5'd8, 5'b00110, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("s3_in_ready", 64'(in_ready),  64'd0);
    check("s3_occ",      64'(occupancy), 64'd2);
    check("s3_pc",       64'(out_pc),    64'h200);
    cycle();
    check("s3_hold_pc",  64'(out_pc),    64'h200);
    check("s3_hold_occ", 64'(occupancy), 64'd2);
    out_ready = 1'b1;
    cycle();
    check("s3_one_pc", 64'(out_pc), 64'h204);
    cycle();
    check_idle("s3_end");
    check("s3_drain", 64'(q32.size()), 64'd0);

    // 4: flush while FULL with a new entry arriving
    out_ready = 1'b0;
    send(32'h280, 32'h2800, 32'h0, 5'd9, 5'b00100, 1'b1);
    cycle();
    send(32'h284, 32'h2804, 32'h0, 5'd10, 5'b00100, 1'b1);
    cycle();
    check("s4_occ_full", 64'(occupancy), 64'd2);
    send(32'h300, 32'h3000, 32'h0, 5'd11, 5'b00100, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    q32.delete(); q64.delete();
    check_idle("s4");
    check("s4_memwrite", 64'(out_memwrite), 64'd0);
    out_ready = 1'b1;
    cycle(); cycle();

    // 5: forwarding tap
    out_ready = 1'b0;
    send(32'h400, 32'hDEAD_BEEF, 32'h1, 5'd5, 5'b00001, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("s5_fwd_en",   64'(fwd_en),   64'd1);
    check("s5_fwd_rd",   64'(fwd_rd),   64'd5);
    check("s5_fwd_data", 64'(fwd_data), 64'hDEAD_BEEF);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    send(32'h404, 32'hDEAD_BEEF, 32'h2, 5'd0, 5'b00001, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("s5_x0_fwd_en",   64'(fwd_en),       64'd0);
    check("s5_x0_regwrite", 64'(out_regwrite), 64'd1);
    out_ready = 1'b1;
    cycle();
    check_idle("s5_end");

    // 6: reset beats flush and release while FULL
    out_ready = 1'b0;
    send(32'h500, 32'h5000, 32'h5, 5'd12, 5'b11111, 1'b1);
    cycle();
    send(32'h504, 32'h5004, 32'h6, 5'd13, 5'b11111, 1'b1);
    cycle();
    send(32'h508, 32'h5008, 32'h7, 5'd14, 5'b11111, 1'b0);
    rst_n = 1'b0; flush = 1'b1; out_ready = 1'b1;
    cycle();
    q32.delete(); q64.delete();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    check_idle("s6");
    check("s6_pc",    64'(out_pc),  64'd0);
    check("s6_alu",   64'(out_alu), 64'd0);
    check("s6_pc64",  out_pc64,     64'd0);
    check("s6_alu64", out_alu64,    64'd0);

    // Recovery: stream again after reset.
    for (int i = 0; i < 3; i++) begin
      send(32'h600 + 32'(4 * i), 32'h60 + 32'(i), 32'h61, 5'(20 + i), 5'b01001, 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    cycle(); cycle();
    check("end_drain32", 64'(q32.size()), 64'd0);
    check("end_drain64", 64'(q64.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
